// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one external signed multiplier between two requesters
// Only one operation is in flight; operands are held for MUL_LAT cycles before the product is captured.
module mul_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_result,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_result,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 busy,
    output logic                 grant_id
);

    localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t               r_state;
    logic                 r_prio;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic                 r_grant;
    logic                 r_busy;
    logic                 r_rsp0_valid;
    logic                 r_rsp1_valid;

    logic                 w_any;
    logic                 w_winner;
    logic                 w_accept;
    logic                 w_rsp_hs;

    // Contention goes to the pointer; a lone requester always wins.
    assign w_any    = req0_valid | req1_valid;
    assign w_winner = (req0_valid && req1_valid) ? r_prio : req1_valid;
    assign w_accept = !rst && (r_state == S_IDLE) && w_any;
    assign w_rsp_hs = r_grant ? rsp1_ready : rsp0_ready;

    assign req0_ready  = w_accept && !w_winner;
    assign req1_ready  = w_accept && w_winner;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_valid ? r_result : '0;
    assign rsp1_result = r_rsp1_valid ? r_result : '0;
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign busy        = r_busy;
    assign grant_id    = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_prio       <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_grant      <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mul_a <= w_winner ? req1_a : req0_a;
                        r_mul_b <= w_winner ? req1_b : req0_b;
                        r_grant <= w_winner;
                        r_prio  <= ~w_winner;
                        r_cnt   <= CW'(MUL_LAT);
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_result     <= mul_result;
                        r_rsp0_valid <= ~r_grant;
                        r_rsp1_valid <= r_grant;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
// Instance a uses MUL_LAT=1, instance b uses MUL_LAT=3; both see an ideal combinational multiplier.
module tb_mul_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_req0_valid = 0, a_req1_valid = 0, a_rsp0_ready = 0, a_rsp1_ready = 0;
    logic [7:0]  a_req0_a = 0, a_req0_b = 0, a_req1_a = 0, a_req1_b = 0;
    logic        a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy, a_grant;
    logic [15:0] a_rsp0_result, a_rsp1_result, a_mul_result;
    logic [7:0]  a_mul_a, a_mul_b;

    logic        b_req0_valid = 0, b_req1_valid = 0, b_rsp0_ready = 0, b_rsp1_ready = 0;
    logic [7:0]  b_req0_a = 0, b_req0_b = 0, b_req1_a = 0, b_req1_b = 0;
    logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy, b_grant;
    logic [15:0] b_rsp0_result, b_rsp1_result, b_mul_result;
    logic [7:0]  b_mul_a, b_mul_b;

    logic signed [15:0] a_prod, b_prod;
    assign a_prod = $signed(a_mul_a) * $signed(a_mul_b);
    assign b_prod = $signed(b_mul_a) * $signed(b_mul_b);
    assign a_mul_result = a_prod;
    assign b_mul_result = b_prod;

    mul_share_arbiter #(.WIDTH(8), .MUL_LAT(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_a(a_req0_a), .req0_b(a_req0_b),
        .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready), .rsp0_result(a_rsp0_result),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_a(a_req1_a), .req1_b(a_req1_b),
        .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready), .rsp1_result(a_rsp1_result),
        .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_result(a_mul_result),
        .busy(a_busy), .grant_id(a_grant)
    );

    mul_share_arbiter #(.WIDTH(8), .MUL_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a), .req0_b(b_req0_b),
        .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_result(b_rsp0_result),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a), .req1_b(b_req1_b),
        .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_result(b_rsp1_result),
        .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_result(b_mul_result),
        .busy(b_busy), .grant_id(b_grant)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_req0_valid = 1'b1;
        a_req1_valid = 1'b1;
        repeat (3) tick();
        checks++; if ({a_req0_ready, a_req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {a_req0_ready, a_req1_ready}); end
        checks++; if ({a_rsp0_valid, a_rsp1_valid, a_busy, a_grant} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {a_rsp0_valid, a_rsp1_valid, a_busy, a_grant}); end
        checks++; if ({a_mul_a, a_mul_b} !== 16'h0000) begin errors++; $display("FAIL reset_mul_ops got %h exp 0000", {a_mul_a, a_mul_b}); end
        checks++; if ({a_rsp0_result, a_rsp1_result} !== 32'h0) begin errors++; $display("FAIL reset_results got %h exp 0", {a_rsp0_result, a_rsp1_result}); end
        rst = 1'b0;
        #1;
        checks++; if ({a_req0_ready, a_req1_ready} !== 2'b10) begin errors++; $display("FAIL post_reset_ready got %b exp 10", {a_req0_ready, a_req1_ready}); end
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_single;
        a_req0_a = 8'd5; a_req0_b = 8'd6; a_req0_valid = 1'b1; a_rsp0_ready = 1'b1; a_rsp1_ready = 1'b1;
        #1;
        checks++; if (a_req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", a_req0_ready); end
        tick();
        a_req0_valid = 1'b0;
        checks++; if ({a_busy, a_rsp0_valid, a_mul_a, a_mul_b} !== {1'b1, 1'b0, 8'd5, 8'd6}) begin errors++; $display("FAIL single_exec got busy=%b v=%b a=%0d b=%0d exp 1 0 5 6", a_busy, a_rsp0_valid, a_mul_a, a_mul_b); end
        tick();
        checks++; if (a_rsp0_valid !== 1'b1 || a_rsp0_result !== 16'd30) begin errors++; $display("FAIL single_result got v=%b r=%0d exp 1 30", a_rsp0_valid, $signed(a_rsp0_result)); end
        checks++; if (a_rsp1_valid !== 1'b0 || a_grant !== 1'b0) begin errors++; $display("FAIL single_other got v1=%b g=%b exp 0 0", a_rsp1_valid, a_grant); end
        tick();
        checks++; if (a_rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", a_rsp0_valid); end
        tick();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", a_busy); end
    endtask

    task automatic test_round_robin;
        logic               exp_port;
        logic signed [15:0] exp_r;
        int                 n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_req0_a = 8'h80; a_req0_b = 8'h80; a_req1_a = 8'd127; a_req1_b = 8'h80;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1; a_rsp0_ready = 1'b1; a_rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            exp_r = exp_port ? -16'sd16256 : 16'sd16384;
            n = 0;
            #1;
            while (!(a_req0_ready || a_req1_ready) && n < 10) begin tick(); n++; end
            checks++; if ({a_req1_ready, a_req0_ready} !== (exp_port ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant_%0d got rdy1,rdy0=%b exp port %0d", k, {a_req1_ready, a_req0_ready}, exp_port); end
            tick();
            n = 0;
            while (!(a_rsp0_valid || a_rsp1_valid) && n < 10) begin tick(); n++; end
            checks++; if ({a_rsp1_valid, a_rsp0_valid} !== (exp_port ? 2'b10 : 2'b01) || a_grant !== exp_port) begin errors++; $display("FAIL rr_rsp_%0d got v1,v0=%b g=%b exp port %0d", k, {a_rsp1_valid, a_rsp0_valid}, a_grant, exp_port); end
            checks++; if ((exp_port ? a_rsp1_result : a_rsp0_result) !== exp_r) begin errors++; $display("FAIL rr_result_%0d got %0d exp %0d", k, $signed(exp_port ? a_rsp1_result : a_rsp0_result), exp_r); end
        end
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_pressure;
        a_req0_a = 8'd100; a_req0_b = 8'hFA; a_req1_a = 8'd3; a_req1_b = 8'd4;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1; a_rsp0_ready = 1'b0; a_rsp1_ready = 1'b1;
        #1;
        checks++; if ({a_req0_ready, a_req1_ready} !== 2'b10) begin errors++; $display("FAIL bp_ready got %b exp 10", {a_req0_ready, a_req1_ready}); end
        tick();
        a_req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_rsp0_valid !== 1'b1 || $signed(a_rsp0_result) !== -16'sd600 || a_req1_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d got v=%b r=%0d rdy1=%b exp 1 -600 0", i, a_rsp0_valid, $signed(a_rsp0_result), a_req1_ready); end
            tick();
        end
        a_rsp0_ready = 1'b1;
        tick();
        checks++; if (a_rsp0_valid !== 1'b0 || a_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v0=%b rdy1=%b exp 0 1", a_rsp0_valid, a_req1_ready); end
        tick();
        a_req1_valid = 1'b0;
        tick();
        checks++; if (a_rsp1_valid !== 1'b1 || a_rsp1_result !== 16'd12) begin errors++; $display("FAIL bp_port1 got v=%b r=%0d exp 1 12", a_rsp1_valid, $signed(a_rsp1_result)); end
        tick();
    endtask

    task automatic test_latency;
        b_req1_a = 8'hD3; b_req1_b = 8'd73; b_req1_valid = 1'b1; b_rsp1_ready = 1'b1;
        #1;
        checks++; if (b_req1_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", b_req1_ready); end
        tick();
        b_req1_valid = 1'b0; b_req1_a = 8'd1; b_req1_b = 8'd1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (b_mul_a !== 8'hD3 || b_mul_b !== 8'd73 || b_rsp1_valid !== 1'b0) begin errors++; $display("FAIL lat_hold_%0d got a=%h b=%0d v=%b exp d3 73 0", i, b_mul_a, b_mul_b, b_rsp1_valid); end
            tick();
        end
        checks++; if (b_rsp1_valid !== 1'b1 || $signed(b_rsp1_result) !== -16'sd3285 || b_grant !== 1'b1) begin errors++; $display("FAIL lat_result got v=%b r=%0d g=%b exp 1 -3285 1", b_rsp1_valid, $signed(b_rsp1_result), b_grant); end
        tick();
        checks++; if (b_rsp1_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL lat_done got v=%b busy=%b exp 0 0", b_rsp1_valid, b_busy); end
    endtask

    task automatic test_reset_mid_op;
        int seen;
        a_req0_a = 8'hAA; a_req0_b = 8'd85; a_req0_valid = 1'b1; a_rsp0_ready = 1'b1; a_rsp1_ready = 1'b1;
        tick();
        a_req0_valid = 1'b0;
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_exec got busy=%b exp 1", a_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({a_busy, a_rsp0_valid, a_rsp1_valid, a_mul_a} !== 11'b0) begin errors++; $display("FAIL mid_reset got busy=%b v0=%b v1=%b a=%h exp 0 0 0 00", a_busy, a_rsp0_valid, a_rsp1_valid, a_mul_a); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_rsp0_valid || a_rsp1_valid || a_busy) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d active cycles exp 0", seen); end
        a_req0_a = 8'd73; a_req0_b = 8'hED; a_req1_a = 8'd5; a_req1_b = 8'd5;
        a_req0_valid = 1'b1; a_req1_valid = 1'b1;
        #1;
        checks++; if ({a_req0_ready, a_req1_ready} !== 2'b10) begin errors++; $display("FAIL mid_prio got %b exp 10", {a_req0_ready, a_req1_ready}); end
        tick();
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        tick();
        checks++; if (a_rsp0_valid !== 1'b1 || $signed(a_rsp0_result) !== -16'sd1387) begin errors++; $display("FAIL mid_next got v=%b r=%0d exp 1 -1387", a_rsp0_valid, $signed(a_rsp0_result)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_latency();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
